// File: rtl/load_store_unit.sv
// RV32I load/store unit: one access at a time over a single-port word memory; error 1, load/SW 2, SB/SH 3 cycles to resp.
// Backpressure: req_ready is high only in IDLE; requests presented while busy are left untouched until accepted.
module load_store_unit #(
  parameter int MEM_AW = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_ren,
  output logic [MEM_AW-1:0] mem_raddr,
  input  logic [31:0]       mem_rdata,
  output logic              mem_wen,
  output logic [MEM_AW-1:0] mem_waddr,
  output logic [31:0]       mem_wdata
);

  typedef enum logic [2:0] {IDLE, LOAD, WRITE, RMW_RD, RMW_WR, DONE} state_t;

  state_t              state_q, state_d;
  logic [2:0]          funct3_q, funct3_d;
  logic [1:0]          boff_q, boff_d;
  logic [MEM_AW-1:0]   widx_q, widx_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         rdata_q, rdata_d;
  logic [31:0]         merge_q, merge_d;
  logic                err_q, err_d;

  logic                acc_err;
  logic [7:0]          lane_b;
  logic [15:0]         lane_h;
  logic [31:0]         load_val;
  logic [31:0]         merged;
  logic                unused_addr_bits;

  // Address bits above the memory window are deliberately dropped.
  assign unused_addr_bits = ^req_addr[31:MEM_AW+2];

  always_comb begin
    acc_err = 1'b0;
    if (req_we) begin
      case (req_funct3)
        3'b000:  acc_err = 1'b0;
        3'b001:  acc_err = req_addr[0];
        3'b010:  acc_err = |req_addr[1:0];
        default: acc_err = 1'b1;
      endcase
    end else begin
      case (req_funct3)
        3'b000, 3'b100: acc_err = 1'b0;
        3'b001, 3'b101: acc_err = req_addr[0];
        3'b010:         acc_err = |req_addr[1:0];
        default:        acc_err = 1'b1;
      endcase
    end
  end

  always_comb begin
    lane_b = mem_rdata[{boff_q, 3'b000} +: 8];
    lane_h = boff_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (funct3_q)
      3'b000:  load_val = {{24{lane_b[7]}}, lane_b};
      3'b001:  load_val = {{16{lane_h[15]}}, lane_h};
      3'b100:  load_val = {24'b0, lane_b};
      3'b101:  load_val = {16'b0, lane_h};
      default: load_val = mem_rdata;
    endcase
    merged = mem_rdata;
    if (!funct3_q[0]) begin
      merged[{boff_q, 3'b000} +: 8] = wdata_q[7:0];
    end else if (boff_q[1]) begin
      merged[31:16] = wdata_q[15:0];
    end else begin
      merged[15:0] = wdata_q[15:0];
    end
  end

  always_comb begin
    state_d    = state_q;
    funct3_d   = funct3_q;
    boff_d     = boff_q;
    widx_d     = widx_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    merge_d    = merge_q;
    err_d      = err_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    mem_ren    = 1'b0;
    mem_wen    = 1'b0;
    mem_wdata  = 32'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          funct3_d = req_funct3;
          boff_d   = req_addr[1:0];
          widx_d   = req_addr[MEM_AW+1:2];
          wdata_d  = req_wdata;
          err_d    = acc_err;
          if (acc_err) begin
            // Errors report zero data, and that zero becomes the held value.
            rdata_d = 32'b0;
            state_d = DONE;
          end else if (!req_we) begin
            state_d = LOAD;
          end else if (req_funct3 == 3'b010) begin
            state_d = WRITE;
          end else begin
            state_d = RMW_RD;
          end
        end
      end
      LOAD: begin
        mem_ren = 1'b1;
        rdata_d = load_val;
        state_d = DONE;
      end
      WRITE: begin
        mem_wen   = 1'b1;
        mem_wdata = wdata_q;
        state_d   = DONE;
      end
      RMW_RD: begin
        mem_ren = 1'b1;
        merge_d = merged;
        state_d = RMW_WR;
      end
      RMW_WR: begin
        mem_wen   = 1'b1;
        mem_wdata = merge_q;
        state_d   = DONE;
      end
      DONE: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      funct3_q <= 3'b0;
      boff_q   <= 2'b0;
      widx_q   <= '0;
      wdata_q  <= 32'b0;
      rdata_q  <= 32'b0;
      merge_q  <= 32'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      funct3_q <= funct3_d;
      boff_q   <= boff_d;
      widx_q   <= widx_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      merge_q  <= merge_d;
      err_q    <= err_d;
    end
  end

  assign resp_rdata = rdata_q;
  assign mem_raddr  = widx_q;
  assign mem_waddr  = widx_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboarded bench for load_store_unit against a behavioural word memory.
module tb_load_store_unit;

  localparam int MEM_AW = 16;

  logic              clk;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic              mem_ren;
  logic [MEM_AW-1:0] mem_raddr;
  logic [31:0]       mem_rdata;
  logic              mem_wen;
  logic [MEM_AW-1:0] mem_waddr;
  logic [31:0]       mem_wdata;

  logic [31:0] mem [0:(1<<MEM_AW)-1];

  typedef struct packed {
    logic        err;
    logic [31:0] rd;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] last_rdata;
  int          checks;
  int          errors;

  load_store_unit #(.MEM_AW(MEM_AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_ren(mem_ren), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_raddr];
  always @(posedge clk) if (mem_wen) mem[mem_waddr] <= mem_wdata;

  // Response monitor: every completion must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && resp_valid) begin
      exp_t e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL resp_unexpected: resp_valid with no outstanding access (rdata=%h err=%b)", resp_rdata, resp_err);
      end else begin
        e = exp_q.pop_front();
        if ({resp_err, resp_rdata} !== {e.err, e.rd}) begin
          errors++;
          $display("FAIL resp_data: got err=%b rdata=%h, expected err=%b rdata=%h", resp_err, resp_rdata, e.err, e.rd);
        end
      end
    end
  end

  task automatic do_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err,
                           input int exp_lat, input logic [31:0] exp_wd, input string name,
                           output int waits);
    int          got_lat;
    logic [7:0]  ren_m, wen_m, exp_ren, exp_wen;
    logic [31:0] wd_seen;
    exp_t        e;
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    waits      = 0;
    while (!req_ready && waits < 10) begin
      @(negedge clk);
      waits++;
    end
    if (!req_ready) begin
      checks++;
      errors++;
      $display("FAIL %s_accept: req_ready=%b after %0d cycles, expected 1", name, req_ready, waits);
      req_valid = 1'b0;
      return;
    end
    e.err      = exp_err;
    e.rd       = (we && !exp_err) ? last_rdata : exp_rd;
    last_rdata = e.rd;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = 32'h0;
    req_wdata = 32'h0;
    got_lat = 0;
    ren_m   = 8'h0;
    wen_m   = 8'h0;
    wd_seen = 32'h0;
    for (int k = 1; k <= 8 && got_lat == 0; k++) begin
      @(negedge clk);
      ren_m[k-1] = mem_ren;
      wen_m[k-1] = mem_wen;
      if (mem_wen) wd_seen = mem_wdata;
      if (resp_valid) got_lat = k;
    end
    if (exp_err)          begin exp_ren = 8'h00; exp_wen = 8'h00; end
    else if (!we)         begin exp_ren = 8'h01; exp_wen = 8'h00; end
    else if (f3 == 3'b010) begin exp_ren = 8'h00; exp_wen = 8'h01; end
    else                  begin exp_ren = 8'h01; exp_wen = 8'h02; end
    checks++;
    if (got_lat !== exp_lat) begin
      errors++;
      $display("FAIL %s_latency: resp_valid at +%0d, expected +%0d", name, got_lat, exp_lat);
    end
    checks++;
    if ({ren_m, wen_m} !== {exp_ren, exp_wen}) begin
      errors++;
      $display("FAIL %s_mem_strobes: ren=%b wen=%b, expected ren=%b wen=%b", name, ren_m, wen_m, exp_ren, exp_wen);
    end
    if (exp_wen != 8'h00) begin
      checks++;
      if (wd_seen !== exp_wd) begin
        errors++;
        $display("FAIL %s_wdata: mem_wdata=%h, expected %h", name, wd_seen, exp_wd);
      end
    end
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b0;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    last_rdata = 32'h0;
    #1;
    checks++;
    if ({req_ready, resp_valid, resp_err, mem_ren, mem_wen} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_ctrl: ready/valid/err/ren/wen=%b, expected 10000", {req_ready, resp_valid, resp_err, mem_ren, mem_wen});
    end
    repeat (2) @(negedge clk);
    checks++;
    if ({resp_rdata, mem_raddr, mem_waddr, mem_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_data: rdata=%h raddr=%h waddr=%h wdata=%h, expected all 0", resp_rdata, mem_raddr, mem_waddr, mem_wdata);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_loads();
    int w;
    do_access(0, 3'b000, 32'h41, 0, 32'hFFFFFFAA, 0, 2, 0, "lb_41", w);
    do_access(0, 3'b100, 32'h41, 0, 32'h000000AA, 0, 2, 0, "lbu_41", w);
    do_access(0, 3'b000, 32'h43, 0, 32'hFFFFFF88, 0, 2, 0, "lb_43", w);
    do_access(0, 3'b001, 32'h40, 0, 32'hFFFFAABB, 0, 2, 0, "lh_40", w);
    do_access(0, 3'b101, 32'h42, 0, 32'h00008899, 0, 2, 0, "lhu_42", w);
    do_access(0, 3'b010, 32'hFFFC0040, 0, 32'h8899AABB, 0, 2, 0, "lw_hi_addr", w);
  endtask

  task automatic test_sb();
    int w;
    do_access(1, 3'b000, 32'h42, 32'h12345611, 0, 0, 3, 32'h8811AABB, "sb_42", w);
    do_access(0, 3'b010, 32'h40, 0, 32'h8811AABB, 0, 2, 0, "lw_after_sb", w);
  endtask

  task automatic test_sh();
    int w;
    do_access(1, 3'b001, 32'h42, 32'hFFFF8001, 0, 0, 3, 32'h8001AABB, "sh_42", w);
    do_access(0, 3'b001, 32'h42, 0, 32'hFFFF8001, 0, 2, 0, "lh_42", w);
    do_access(0, 3'b101, 32'h42, 0, 32'h00008001, 0, 2, 0, "lhu_42b", w);
  endtask

  task automatic test_errors();
    int w;
    do_access(0, 3'b010, 32'h42, 0, 32'h0, 1, 1, 0, "lw_misaligned", w);
    do_access(0, 3'b011, 32'h40, 0, 32'h0, 1, 1, 0, "load_f3_011", w);
    do_access(1, 3'b001, 32'h41, 32'h1234, 32'h0, 1, 1, 0, "sh_misaligned", w);
    do_access(1, 3'b100, 32'h40, 32'h1234, 32'h0, 1, 1, 0, "store_f3_100", w);
    checks++;
    if (mem[16'h0010] !== 32'h8001AABB) begin
      errors++;
      $display("FAIL err_no_write: mem[0x10]=%h, expected 8001aabb", mem[16'h0010]);
    end
  endtask

  task automatic test_back_to_back();
    int w;
    do_access(1, 3'b010, 32'h40, 32'hDEADBEEF, 0, 0, 2, 32'hDEADBEEF, "sw_40", w);
    checks++;
    if (req_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_ready_in_done: req_ready=%b, expected 0", req_ready);
    end
    do_access(0, 3'b010, 32'h40, 0, 32'hDEADBEEF, 0, 2, 0, "lw_b2b", w);
    checks++;
    if (w !== 1) begin
      errors++;
      $display("FAIL b2b_accept_gap: accepted after %0d wait cycles, expected 1", w);
    end
  endtask

  task automatic test_reset_mid();
    int w;
    int wen_seen;
    int resp_seen;
    int guard;
    @(negedge clk);
    guard = 0;
    while (!req_ready && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'b000;
    req_addr   = 32'h40;
    req_wdata  = 32'h00000077;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_ren !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_rmw_rd: mem_ren=%b, expected 1", mem_ren);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({req_ready, mem_ren, mem_wen, resp_valid, mem_raddr} !== {4'b1000, {MEM_AW{1'b0}}}) begin
      errors++;
      $display("FAIL rst_mid_immediate: ready=%b ren=%b wen=%b valid=%b raddr=%h, expected 1 0 0 0 0",
               req_ready, mem_ren, mem_wen, resp_valid, mem_raddr);
    end
    wen_seen  = 0;
    resp_seen = 0;
    repeat (3) begin
      @(negedge clk);
      wen_seen  += int'(mem_wen);
      resp_seen += int'(resp_valid);
    end
    checks++;
    if (wen_seen != 0 || resp_seen != 0 || mem[16'h0010] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL rst_mid_abort: wen=%0d resp=%0d mem=%h, expected 0 0 deadbeef", wen_seen, resp_seen, mem[16'h0010]);
    end
    rst_n      = 1'b1;
    last_rdata = 32'h0;
    do_access(0, 3'b010, 32'h40, 0, 32'hDEADBEEF, 0, 2, 0, "lw_after_rst", w);
    checks++;
    if (w !== 0) begin
      errors++;
      $display("FAIL rst_first_accept: waited %0d cycles, expected 0", w);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    mem[16'h0010] = 32'h8899AABB;
    test_reset();
    test_loads();
    test_sb();
    test_sh();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d responses outstanding, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter MEM_AW, default 16: memory word-address width; byte address is MEM_AW+2 bits.
REQ-002 SHALL have one clock and an asynchronous, active-low reset.
REQ-003 SHALL have clk input 1: sole clock, rising edge.
REQ-004 SHALL have rst_n input 1: asynchronous active-low reset.
REQ-005 SHALL have req_valid input 1: core presents an access.
REQ-006 SHALL have req_ready output 1: unit accepts an access this cycle.
REQ-007 SHALL have req_we input 1: 1 means store, 0 means load.
REQ-008 SHALL have req_funct3 input 3: RV32I width/sign code.
REQ-009 SHALL have req_addr input 32: byte address; bits above MEM_AW+1 are ignored.
REQ-010 SHALL have req_wdata input 32: store data, right-aligned.
REQ-011 SHALL have resp_valid output 1: one-cycle completion pulse.
REQ-012 SHALL have resp_rdata output 32: extended load data, valid with resp_valid.
REQ-013 SHALL have resp_err output 1: access rejected, qualified by resp_valid.
REQ-014 SHALL have mem_ren output 1, memory read enable.
REQ-015 SHALL have mem_raddr output MEM_AW, memory read word address.
REQ-016 SHALL have mem_rdata input 32: combinational memory read data, same cycle as mem_ren.
REQ-017 SHALL have mem_wen output 1: memory write enable, written on the next rising edge.
REQ-018 SHALL have mem_waddr output MEM_AW, memory write word address.
REQ-019 SHALL have mem_wdata output 32, memory write data.

Function
REQ-020 SHALL implement states IDLE, LOAD, WRITE, RMW_RD, RMW_WR and DONE.
REQ-021 SHALL assert req_ready only in IDLE; an access is accepted when req_valid=1 and req_ready=1, latching all req_* fields.
REQ-022 SHALL set the word index to latched addr[MEM_AW+1:2], driven on mem_raddr and mem_waddr in every state except after reset (0); byte order is little-endian.
REQ-023 SHALL decode loads as 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU, and stores as 000 SB, 001 SH, 010 SW.
REQ-024 SHALL treat any other funct3 as an error.
REQ-025 SHALL treat as misaligned: halfword with addr[0]=1, and word with addr[1:0]!=0.
REQ-026 SHALL make the IDLE transition on accept: error goes to DONE; load goes to LOAD; SW goes to WRITE; SB/SH go to RMW_RD.
REQ-027 SHALL, in LOAD, assert mem_ren=1 and register the selected lane of mem_rdata into resp_rdata, then go to DONE.
REQ-028 SHALL sign-extend LB/LH lanes and zero-extend LBU/LHU lanes; LW SHALL return the full word.
REQ-029 SHALL, in WRITE, assert mem_wen=1 with mem_wdata=req_wdata, then go to DONE.
REQ-030 SHALL, in RMW_RD, assert mem_ren=1 and register mem_rdata with req_wdata[7:0] or [15:0] merged into the addressed lane, then go to RMW_WR.
REQ-031 SHALL, in RMW_WR, assert mem_wen=1 with the merged word on mem_wdata, then go to DONE.
REQ-032 SHALL, in DONE, assert resp_valid=1 for exactly one cycle, then return to IDLE.
REQ-033 SHALL, in DONE, drive resp_err=1 and resp_rdata=0 for errors, and resp_err=0 otherwise.
REQ-034 SHALL have these latencies from the accept edge to the cycle resp_valid=1:
- error: 1 cycle
- load and SW: 2 cycles
- SB/SH: 3 cycles
REQ-035 SHALL allow the next accept no earlier than the cycle after DONE.
REQ-036 SHALL hold resp_rdata stable until the next load or error completes.
REQ-037 SHALL, for error accesses, assert neither mem_ren nor mem_wen.
REQ-038 SHALL assert mem_wen for at most one cycle per store.
REQ-039 SHALL deassert mem_ren and mem_wen in all states other than those stated above.
REQ-040 SHALL clear mem_wdata to 0 outside WRITE and RMW_WR.
REQ-041 SHALL ignore req_valid while req_ready=0; such requests are neither latched nor dropped-and-acknowledged.

Reset
REQ-042 SHALL, while rst_n=0, immediately force:
- state to IDLE and req_ready=1
- resp_valid, resp_err, mem_ren and mem_wen to 0
- resp_rdata, mem_raddr, mem_waddr and mem_wdata to 0
REQ-043 SHALL, on reset mid-access, abort the access with no write and no response; the first accept is possible in the first cycle after release.

Verification
REQ-044 SHALL cover, with memory word 0x0010 = 0x8899AABB: LB addr 0x41 gives resp_rdata 0xFFFFFFAA at +2, and LBU addr 0x41 gives 0x000000AA.
REQ-045 SHALL cover SB addr 0x42, wdata 0x12345611: mem_wen high only at +2 with mem_wdata 0x8811AABB, resp_valid at +3, and a following LW 0x40 returns 0x8811AABB.
REQ-046 SHALL cover SH addr 0x42, wdata 0xFFFF8001, then LH 0x42 gives 0xFFFF8001 and LHU 0x42 gives 0x00008001.
REQ-047 SHALL cover LW addr 0x42 (misaligned) and a load with funct3 011: each gives resp_valid with resp_err=1 and resp_rdata=0 at +1, with no mem_ren/mem_wen.
REQ-048 SHALL cover SW addr 0x40, wdata 0xDEADBEEF, issued back-to-back with LW 0x40: the LW is accepted at the cycle after DONE and returns 0xDEADBEEF.
REQ-049 SHALL cover rst_n pulsed low during RMW_RD of SB 0x40: no mem_wen, no resp_valid, memory unchanged, and req_ready=1 after release.
